score_history_reader: RTL and testbench
=======================================

# score_history_reader

Read-side companion to the score ring writer. While the menu FSM is in the view-score state, it fetches archived game scores from the 256-entry score memory, newest first. It converts each fetched score to packed BCD for the seven-segment/VGA digit renderer. Keyboard-decoded next/prev pulses step through the history.

## Interface
- DEPTH_LOG2, 8, score ring address width; ring holds 2^DEPTH_LOG2 entries
- SCORE_WIDTH, 32, width of a stored score
- DIGITS, 10, BCD digits produced; 4*DIGITS bits must cover 2^SCORE_WIDTH-1
- READ_LATENCY, 2, edges from a readAddress update until readData is valid; legal range 1..3
- Clock  in  1  single design clock; all logic on posedge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
- ld_score  in  1  level; high while the top-level FSM is in the view-score state
- writeAddress  in  DEPTH_LOG2  writer's current slot; holds the most recent score
- next  in  1  one-cycle pulse; step to an older entry
- prev  in  1  one-cycle pulse; step to a newer entry
- readData  in  SCORE_WIDTH  score memory q
- readAddress  out  DEPTH_LOG2  registered score memory read address
- entryIndex  out  DEPTH_LOG2  age of the displayed entry; 0 = newest
- shownScore  out  SCORE_WIDTH  binary score captured from memory
- bcd  out  4*DIGITS  packed BCD of shownScore; digit 0 in bits [3:0]
- blank  out  DIGITS  per-digit leading-zero blank flags
- valid  out  1  bcd, blank and shownScore are stable and match entryIndex
- busy  out  1  fetch or conversion in progress

## Operation
- Reset values: all outputs 0. FSM goes to IDLE. Offset counter is 0.
- States: IDLE, ISSUE, WAIT, CONVERT, SHOW.
- IDLE → ISSUE when ld_score=1. On that edge, entryIndex is set to 0.
- ISSUE drives `readAddress <= writeAddress - entryIndex`, computed mod 2^DEPTH_LOG2. This wraps, e.g. writeAddress 2, index 5 → address 253.
- WAIT counts READ_LATENCY edges from the readAddress update. On the final edge it captures readData into shownScore, clears the BCD shift register and goes to CONVERT.
- CONVERT runs double-dabble, one bit per edge, MSB first, for exactly SCORE_WIDTH edges. Add-3 is applied to each digit ≥5 before each shift. The result is loaded into bcd on the last edge, and the state goes to SHOW.
- SHOW: valid=1, busy=0.
  - next increments entryIndex, saturating at 2^DEPTH_LOG2-1.
  - prev decrements entryIndex, saturating at 0.
  - A pulse that changes entryIndex clears valid and goes to ISSUE.
  - A saturated pulse, or next and prev high on the same edge, is ignored; valid stays 1.
- busy=1 in ISSUE, WAIT and CONVERT. next/prev are ignored whenever busy=1.
- If ld_score=0 in any state, the next edge goes to IDLE with valid=0 and busy=0. bcd, shownScore and entryIndex hold their last values. The following entry restarts at index 0.
- If writeAddress changes during a fetch, the new value is sampled only in ISSUE. An in-flight fetch completes with the old address.
- reset mid-operation has priority over everything and yields the reset values on the same edge.

## Timing
- Let E0 be the edge that leaves IDLE or SHOW. readAddress updates at E0+1 (ISSUE).
- shownScore is captured at E0+1+READ_LATENCY.
- bcd is loaded and valid rises at E0+1+READ_LATENCY+SCORE_WIDTH. With defaults that is E0+35.
- valid and busy are never both 1. valid falls on the edge that accepts a step or sees ld_score=0.
- readAddress changes only in ISSUE, once per fetch.

## Configuration
- SCORE_READER_BLANK_EN defined:
  - blank[i]=1 for every digit i>0 above the most significant nonzero digit.
  - blank is computed in the CONVERT final edge and is valid with bcd.
  - Digit 0 is never blanked, so score 0 shows a single "0".
- Not defined: blank is constant 0 and no blanking logic is synthesized. All other behaviour is identical.

## Test plan
- **Entry and first fetch.** Reset, then writeAddress=7, memory[7]=1234, ld_score 0→1.
  - readAddress=7 at E0+1.
  - valid at E0+35 with bcd=0x0000001234 and entryIndex=0.
  - With the macro, blank=10'b1111110000.
- **Wrap-around.** writeAddress=1, memory[255]=42.
  - Two next pulses give entryIndex=2 and readAddress=255.
  - bcd ends at 0x0000000042.
- **Saturation and ignored steps.** At entryIndex=0, prev leaves valid=1 with no refetch.
  - next and prev on the same edge: ignored.
  - next during CONVERT: ignored, entryIndex unchanged.
- **Maximum value.** memory[x]=32'hFFFFFFFF → bcd=0x4294967295. With the macro, blank=0.
- **Abort.** Drop ld_score during WAIT: next edge gives valid=0 and busy=0.
  - Raise ld_score again: the fetch restarts at index 0.
- **Reset mid-CONVERT.** reset=1 for one edge: all outputs are 0 and the state is IDLE on that edge.

Source files
------------

// File: rtl/score_history_reader.sv
// Fetches archived scores newest-first from the score ring and converts them to packed BCD.
// Optional leading-zero blanking is enabled with SCORE_READER_BLANK_EN.
module score_history_reader #(
  parameter int DEPTH_LOG2   = 8,
  parameter int SCORE_WIDTH  = 32,
  parameter int DIGITS       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic                    Clock,
  input  logic                    reset,
  input  logic                    ld_score,
  input  logic [DEPTH_LOG2-1:0]   writeAddress,
  input  logic                    next,
  input  logic                    prev,
  input  logic [SCORE_WIDTH-1:0]  readData,
  output logic [DEPTH_LOG2-1:0]   readAddress,
  output logic [DEPTH_LOG2-1:0]   entryIndex,
  output logic [SCORE_WIDTH-1:0]  shownScore,
  output logic [4*DIGITS-1:0]     bcd,
  output logic [DIGITS-1:0]       blank,
  output logic                    valid,
  output logic                    busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CONVERT, SHOW} state_t;

  localparam int CNT_W = (SCORE_WIDTH > 1) ? $clog2(SCORE_WIDTH) : 1;
  localparam logic [DEPTH_LOG2-1:0] MAX_INDEX = '1;

  state_t                  state, state_next;
  logic [1:0]              wait_cnt;
  logic [CNT_W-1:0]        bit_cnt;
  logic [SCORE_WIDTH-1:0]  bin_sr;
  logic [4*DIGITS-1:0]     bcd_sr, bcd_adj, bcd_step;
  logic                    wait_done, conv_done, step_older, step_newer;

  assign wait_done  = (wait_cnt == 2'(READ_LATENCY - 1));
  assign conv_done  = (bit_cnt == CNT_W'(SCORE_WIDTH - 1));
  assign step_older = next && !prev && (entryIndex != MAX_INDEX);
  assign step_newer = prev && !next && (entryIndex != '0);

  always_ff @(posedge Clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid      = (state == SHOW);
    busy       = (state == ISSUE) || (state == WAIT) || (state == CONVERT);
    if (!ld_score) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ISSUE;
        ISSUE:   state_next = WAIT;
        WAIT:    if (wait_done) state_next = CONVERT;
        CONVERT: if (conv_done) state_next = SHOW;
        SHOW:    if (step_older || step_newer) state_next = ISSUE;
        default: state_next = IDLE;
      endcase
    end
  end

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[4*DIGITS-2:0], bin_sr[SCORE_WIDTH-1]};
  end

`ifdef SCORE_READER_BLANK_EN
  logic [DIGITS-1:0] blank_next;
  logic              blank_seen;

  always_comb begin
    blank_next = '0;
    blank_seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (bcd_step[4*i +: 4] != 4'd0) blank_seen = 1'b1;
      blank_next[i] = !blank_seen;
    end
  end
`else
  assign blank = '0;
`endif

  always_ff @(posedge Clock) begin
    if (reset) begin
      readAddress <= '0;
      entryIndex  <= '0;
      shownScore  <= '0;
      bcd         <= '0;
      wait_cnt    <= '0;
      bit_cnt     <= '0;
      bin_sr      <= '0;
      bcd_sr      <= '0;
`ifdef SCORE_READER_BLANK_EN
      blank       <= '0;
`endif
    end else if (ld_score) begin
      case (state)
        IDLE: entryIndex <= '0;
        ISSUE: begin
          readAddress <= writeAddress - entryIndex;
          wait_cnt    <= '0;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 2'd1;
          if (wait_done) begin
            shownScore <= readData;
            bin_sr     <= readData;
            bcd_sr     <= '0;
            bit_cnt    <= '0;
          end
        end
        CONVERT: begin
          bcd_sr  <= bcd_step;
          bin_sr  <= bin_sr << 1;
          bit_cnt <= bit_cnt + 1'b1;
          if (conv_done) begin
            bcd <= bcd_step;
`ifdef SCORE_READER_BLANK_EN
            blank <= blank_next;
`endif
          end
        end
        SHOW: begin
          if (step_older)      entryIndex <= entryIndex + 1'b1;
          else if (step_newer) entryIndex <= entryIndex - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_score_history_reader.sv
// Scoreboard bench for score_history_reader: a reference model predicts every fetch,
// a monitor pops and compares each time valid rises.
module tb_score_history_reader;

  localparam int DL  = 8;
  localparam int SW  = 32;
  localparam int DG  = 10;
  localparam int RL  = 2;
  localparam int LAT = 1 + RL + SW;
`ifdef SCORE_READER_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          reset, ld_score, next, prev;
  logic [DL-1:0] writeAddress, readAddress, entryIndex;
  logic [SW-1:0] readData, shownScore;
  logic [4*DG-1:0] bcd;
  logic [DG-1:0] blank;
  logic          valid, busy;

  always #5 Clock = ~Clock;

  score_history_reader #(
    .DEPTH_LOG2(DL), .SCORE_WIDTH(SW), .DIGITS(DG), .READ_LATENCY(RL)
  ) dut (
    .Clock(Clock), .reset(reset), .ld_score(ld_score), .writeAddress(writeAddress),
    .next(next), .prev(prev), .readData(readData), .readAddress(readAddress),
    .entryIndex(entryIndex), .shownScore(shownScore), .bcd(bcd), .blank(blank),
    .valid(valid), .busy(busy)
  );

  // Score memory with one register stage: data is usable two edges after an address update.
  logic [SW-1:0] mem [256];
  always @(posedge Clock) readData <= mem[readAddress];

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  typedef struct {
    logic [DL-1:0]   idx;
    logic [DL-1:0]   addr;
    logic [SW-1:0]   score;
    logic [4*DG-1:0] bcd;
    logic [DG-1:0]   blank;
    int              cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   passes = 0;
  int   model_idx;
  int   model_wa;
  logic valid_q = 1'b0;

  function automatic logic [4*DG-1:0] bcdOf(input logic [SW-1:0] s);
    longint v;
    logic [4*DG-1:0] r;
    v = longint'(s);
    r = '0;
    for (int i = 0; i < DG; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [DG-1:0] blankOf(input logic [SW-1:0] s);
    longint v;
    int nd;
    logic [DG-1:0] r;
    v  = longint'(s);
    nd = 1;
    while (v >= 10) begin
      v  = v / 10;
      nd = nd + 1;
    end
    r = '0;
    for (int i = nd; i < DG; i++) r[i] = 1'b1;
    return BLANK_EN ? r : '0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic pushExpect();
    exp_t e;
    e.idx   = DL'(model_idx);
    e.addr  = DL'((model_wa - model_idx + 256) % 256);
    e.score = mem[e.addr];
    e.bcd   = bcdOf(e.score);
    e.blank = blankOf(e.score);
    e.cyc   = cyc + LAT;
    exp_q.push_back(e);
  endtask

  always @(posedge Clock) begin
    #1;
    checkOutput("valid_busy_exclusive", {63'd0, valid && busy}, 64'd0);
    if (valid && !valid_q) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", {63'd0, valid}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("sb_entryIndex", entryIndex, mon_e.idx);
        checkOutput("sb_readAddress", readAddress, mon_e.addr);
        checkOutput("sb_shownScore", shownScore, mon_e.score);
        checkOutput("sb_bcd", bcd, mon_e.bcd);
        checkOutput("sb_blank", blank, mon_e.blank);
        checkOutput("sb_valid_cycle", cyc, mon_e.cyc);
      end
    end
    valid_q = valid;
  end

  task automatic waitValid();
    int n = 0;
    while (valid !== 1'b1 && n < 100) begin
      @(posedge Clock);
      #1;
      n++;
    end
    checkOutput("valid_timeout", {63'd0, valid}, 64'd1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_readAddress", readAddress, 0);
    checkOutput("rst_entryIndex", entryIndex, 0);
    checkOutput("rst_shownScore", shownScore, 0);
    checkOutput("rst_bcd", bcd, 0);
    checkOutput("rst_blank", blank, 0);
    checkOutput("rst_valid", {63'd0, valid}, 0);
    checkOutput("rst_busy", {63'd0, busy}, 0);
  endtask

  task automatic enterView(input int wa);
    @(negedge Clock);
    writeAddress = DL'(wa);
    model_wa     = wa;
    model_idx    = 0;
    ld_score     = 1'b1;
    @(posedge Clock);
    #1;
    pushExpect();
    @(posedge Clock);
    #1;
    checkOutput("entry_readAddress", readAddress, wa);
    checkOutput("entry_busy", {63'd0, busy}, 1);
  endtask

  // show=1 means the DUT is known to be in its display state when the pulse lands.
  task automatic applyStimulus(input bit n, input bit p, input bit push, input bit show);
    bit acc;
    @(negedge Clock);
    next = n;
    prev = p;
    acc  = show && (n != p) && (n ? (model_idx != 255) : (model_idx != 0));
    @(posedge Clock);
    #1;
    if (acc) begin
      model_idx = n ? model_idx + 1 : model_idx - 1;
      if (push) pushExpect();
      checkOutput("step_valid_drop", {63'd0, valid}, 0);
    end else if (show) begin
      checkOutput("ignored_step_valid", {63'd0, valid}, 1);
      checkOutput("ignored_step_busy", {63'd0, busy}, 0);
      checkOutput("ignored_step_index", entryIndex, model_idx);
    end
    @(negedge Clock);
    next = 1'b0;
    prev = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_score = 1'b0; next = 1'b0; prev = 1'b0; writeAddress = '0;
    for (int i = 0; i < 256; i++) mem[i] = (i % 3 == 0) ? $urandom_range(0, 99999) : $urandom;
    repeat (2) @(posedge Clock);
    #1;
    checkResetState();
    @(negedge Clock);
    reset = 1'b0;

    // First entry: newest slot 7
    mem[7] = 32'd1234;
    enterView(7);
    waitValid();
    checkOutput("first_bcd", bcd, 40'h0000001234);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);

    // Wrap-around below slot 0
    @(negedge Clock);
    writeAddress = 8'd1;
    model_wa     = 1;
    mem[255]     = 32'd42;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitValid();
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitValid();
    checkOutput("wrap_readAddress", readAddress, 255);
    checkOutput("wrap_bcd", bcd, 40'h0000000042);

    // A step while converting must be ignored
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (10) @(posedge Clock);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    waitValid();
    checkOutput("convert_step_ignored", entryIndex, 3);

    // Largest score
    mem[253] = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
    waitValid();
    checkOutput("max_bcd", bcd, 40'h4294967295);

    // Abort during the memory wait
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge Clock);
    @(negedge Clock);
    ld_score = 1'b0;
    @(posedge Clock);
    #1;
    checkOutput("abort_valid", {63'd0, valid}, 0);
    checkOutput("abort_busy", {63'd0, busy}, 0);
    checkOutput("abort_index_hold", entryIndex, 5);
    checkOutput("abort_bcd_hold", bcd, 40'h4294967295);
    checkOutput("abort_score_hold", shownScore, 32'hFFFF_FFFF);

    enterView($urandom_range(0, 255));
    waitValid();

    // Random walk through the history
    for (int k = 0; k < 16; k++) begin
      int r;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge Clock);
        model_wa     = $urandom_range(0, 255);
        writeAddress = DL'(model_wa);
      end
      r = $urandom_range(0, 3);
      applyStimulus(r != 1, r != 0 && r != 3, 1'b1, 1'b1);
      waitValid();
    end

    // Reset in the middle of a conversion
    applyStimulus(model_idx != 255, model_idx == 255, 1'b0, 1'b1);
    repeat (8) @(posedge Clock);
    @(negedge Clock);
    reset = 1'b1;
    @(posedge Clock);
    #1;
    checkResetState();
    @(negedge Clock);
    reset    = 1'b0;
    ld_score = 1'b0;
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
